pio_f2h_fifo: RTL and testbench

Parametrised FPGA-to-HPS parallel-I/O read port with elastic buffering. FPGA-side logic pushes words through a valid/ready interface into a DEPTH-entry FIFO. The HPS bridge pops words, or reads a status word, through a single-cycle registered read port. The block adds sticky overflow/underflow flags and a host-controlled flush, neither of which the fixed 32-bit capture register has.

---
 rtl/pio_f2h_fifo.sv | 94 +++++++++
 tb/tb_pio_f2h_fifo.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pio_f2h_fifo.sv
// FPGA-to-HPS read port: valid/ready push side into a DEPTH-entry FIFO, registered
// single-cycle host read of data (pop) or status, with sticky overflow/underflow flags.
module pio_f2h_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   input  logic              rd_en,
   input  logic              rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              ctrl_wr,
   input  logic [1:0]        ctrl_wdata
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              ovf, udf;

   logic empty, full, flush, clr, rd_data_sel;
   logic do_push, do_pop, ovf_evt, udf_evt;
   logic [DATA_W-1:0] status_word;

   // Push side: a word transfers on any cycle with wr_valid && wr_ready; wr_valid
   // while not ready is not stalled but dropped and recorded as overflow.
   assign empty       = (count == '0);
   assign full        = (count == CNT_W'(DEPTH));
   assign wr_ready    = !full;
   assign flush       = ctrl_wr && ctrl_wdata[0];
   assign clr         = ctrl_wr && ctrl_wdata[1];
   assign rd_data_sel = rd_en && !rd_addr;
   assign do_push     = wr_valid && !full && !flush;
   assign do_pop      = rd_data_sel && !empty && !flush;
   assign ovf_evt     = wr_valid && full && !flush;
   assign udf_evt     = rd_data_sel && empty && !flush;

   always_comb begin
      status_word              = '0;
      status_word[0]           = empty;
      status_word[1]           = full;
      status_word[2]           = ovf;
      status_word[3]           = udf;
      status_word[16 +: CNT_W] = count;
   end

   // Storage is intentionally left out of reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         ovf      <= 1'b0;
         udf      <= 1'b0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            if (rd_addr)     rd_data <= status_word;
            else if (do_pop) rd_data <= mem[rd_ptr];
            else             rd_data <= '0;
         end

         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
         end

         // A same-cycle event beats a clear.
         if (ovf_evt)  ovf <= 1'b1;
         else if (clr) ovf <= 1'b0;
         if (udf_evt)  udf <= 1'b1;
         else if (clr) udf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pio_f2h_fifo.sv
// Bench for pio_f2h_fifo (DEPTH=4): directed scenarios then random traffic with
// mid-run resets, compared cycle by cycle against a queue-based reference model.
module tb_pio_f2h_fifo;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              wr_valid;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ready;
   logic              rd_en;
   logic              rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              ctrl_wr;
   logic [1:0]        ctrl_wdata;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [DATA_W-1:0] exp_q[$];
   logic              m_ovf, m_udf;
   logic [DATA_W-1:0] m_rd_data;
   logic              m_rd_valid;

   pio_f2h_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_valid   (wr_valid),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .ctrl_wr    (ctrl_wr),
      .ctrl_wdata (ctrl_wdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [DATA_W-1:0] model_status();
      logic [DATA_W-1:0] s;
      s        = '0;
      s[0]     = (exp_q.size() == 0);
      s[1]     = (exp_q.size() == DEPTH);
      s[2]     = m_ovf;
      s[3]     = m_udf;
      s[18:16] = 3'(exp_q.size());
      return s;
   endfunction

   task automatic model_clear();
      exp_q.delete();
      m_ovf      = 1'b0;
      m_udf      = 1'b0;
      m_rd_data  = '0;
      m_rd_valid = 1'b0;
   endtask

   // Drive one cycle of inputs, advance the model, then compare after the edge.
   task automatic cycle(input logic wv, input logic [DATA_W-1:0] wd, input logic re,
                        input logic ra, input logic cw, input logic [1:0] cd);
      logic flush, clr, was_full, ovf_ev, udf_ev;
      wr_valid   = wv;
      wr_data    = wd;
      rd_en      = re;
      rd_addr    = ra;
      ctrl_wr    = cw;
      ctrl_wdata = cd;

      flush    = cw && cd[0];
      clr      = cw && cd[1];
      was_full = (exp_q.size() == DEPTH);
      ovf_ev   = 1'b0;
      udf_ev   = 1'b0;
      m_rd_valid = re;
      if (re) begin
         if (ra)                    m_rd_data = model_status();
         else if (flush)            m_rd_data = '0;
         else if (exp_q.size() == 0) begin
            m_rd_data = '0;
            udf_ev    = 1'b1;
         end else                   m_rd_data = exp_q.pop_front();
      end
      if (wv && !flush) begin
         if (was_full) ovf_ev = 1'b1;
         else          exp_q.push_back(wd);
      end
      if (flush) exp_q.delete();
      if (ovf_ev)   m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (udf_ev)   m_udf = 1'b1;
      else if (clr) m_udf = 1'b0;

      @(posedge clk);
      #1;
      check("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
      check("rd_data", rd_data, m_rd_data);
      check("wr_ready", 32'(wr_ready), 32'(exp_q.size() < DEPTH));
   endtask

   task automatic idle();
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 2'b00);
   endtask

   task automatic push(input logic [DATA_W-1:0] d);
      cycle(1'b1, d, 1'b0, 1'b0, 1'b0, 2'b00);
   endtask

   task automatic pop();
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 2'b00);
   endtask

   task automatic status_rd();
      cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, 2'b00);
   endtask

   // Asynchronous reset applied away from the clock edge.
   task automatic do_reset();
      wr_valid = 1'b0; rd_en = 1'b0; rd_addr = 1'b0; ctrl_wr = 1'b0; ctrl_wdata = 2'b00;
      wr_data  = '0;
      rst_n = 1'b0;
      #2;
      model_clear();
      check("rst_rd_data", rd_data, '0);
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check("rst_wr_ready", 32'(wr_ready), 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      wr_valid = 1'b0; wr_data = '0; rd_en = 1'b0; rd_addr = 1'b0;
      ctrl_wr = 1'b0; ctrl_wdata = 2'b00;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // Reset status
      status_rd();
      check("status_reset", rd_data, 32'h0000_0001);

      // Ordered data return
      push(32'hA1); push(32'hA2); push(32'hA3);
      pop(); check("pop_a1", rd_data, 32'hA1);
      pop(); check("pop_a2", rd_data, 32'hA2);
      pop(); check("pop_a3", rd_data, 32'hA3);
      status_rd(); check("status_empty", rd_data, 32'h0000_0001);

      // Overflow: fifth word dropped
      for (int i = 0; i < 5; i++) begin
         push(32'h10 + 32'(i));
         if (i == 3) check("full_after_4", 32'(wr_ready), 32'd0);
      end
      status_rd(); check("status_full_ovf", rd_data, 32'h0004_0006);
      for (int i = 0; i < 4; i++) begin
         pop(); check("pop_ovf_seq", rd_data, 32'h10 + 32'(i));
      end

      // Wrap-around with simultaneous push/pop at count 1
      push(32'hB0);
      for (int i = 1; i <= 6; i++) begin
         cycle(1'b1, 32'hB0 + 32'(i), 1'b1, 1'b0, 1'b0, 2'b00);
         check("wrap_data", rd_data, 32'hB0 + 32'(i - 1));
      end
      status_rd(); check("wrap_count1", rd_data, 32'h0001_0004);
      pop(); check("wrap_last", rd_data, 32'hB6);

      // Underflow, then clear sticky flags
      pop(); check("udf_data", rd_data, '0);
      status_rd(); check("udf_status", rd_data, 32'h0000_000D);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 2'b10);
      status_rd(); check("cleared_status", rd_data, 32'h0000_0001);

      // Flush with simultaneous push
      push(32'hC1); push(32'hC2); push(32'hC3);
      cycle(1'b1, 32'hC4, 1'b0, 1'b0, 1'b1, 2'b01);
      status_rd(); check("flush_status", rd_data, 32'h0000_0001);

      // Pop during empty with push in same cycle: underflow, push accepted
      cycle(1'b1, 32'hD1, 1'b1, 1'b0, 1'b0, 2'b00);
      status_rd(); check("empty_pushpop", rd_data, 32'h0001_0008);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 2'b10);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         logic wv, re, ra, cw;
         logic [1:0] cd;
         wv = ($urandom_range(0, 99) < 60);
         re = ($urandom_range(0, 99) < 50);
         ra = ($urandom_range(0, 99) < 20);
         cw = ($urandom_range(0, 99) < 4);
         cd = 2'($urandom_range(0, 3));
         cycle(wv, $urandom, re, ra, cw, cd);
         if ($urandom_range(0, 499) == 0) begin
            do_reset();
            status_rd();
            check("status_after_rst", rd_data, 32'h0000_0001);
         end
         if (i == 1500) idle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
